// File: rtl/pattern_checker.sv
// pattern_checker: scoreboard for the pattern-finder bench.
// Paces the vector reader, delays each vector's expected 1st/2nd CLCT
// results by the finder latency and compares them against the finder's
// actual outputs. Reports vector count, saturating error count, the first
// failing address and the final pass/fail verdict.
module pattern_checker #(
  parameter int MXADRB    = 10,
  parameter int LATENCY   = 4,
  parameter int MXERRB    = 16,
  parameter int CMP_CCODE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rdr_done,
  input  logic [MXADRB-1:0] rdr_adr,
  input  logic [7:0]        key_hs_expect_1st,
  input  logic [7:0]        key_hs_expect_2nd,
  input  logic [11:0]       ccode_expect_1st,
  input  logic [11:0]       ccode_expect_2nd,
  input  logic [3:0]        pat_expect_1st,
  input  logic [3:0]        pat_expect_2nd,
  input  logic [7:0]        hs_key_1st,
  input  logic [7:0]        hs_key_2nd,
  input  logic [11:0]       hs_ccode_1st,
  input  logic [11:0]       hs_ccode_2nd,
  input  logic [3:0]        hs_pat_1st,
  input  logic [3:0]        hs_pat_2nd,
  output logic              increment,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MXADRB:0]   vec_cnt,
  output logic [MXERRB-1:0] err_cnt,
  output logic              first_err_valid,
  output logic [MXADRB-1:0] first_err_adr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Expected results of one vector as they travel down the delay line.
  typedef struct packed {
    logic [7:0]  key_1st;
    logic [7:0]  key_2nd;
    logic [11:0] ccode_1st;
    logic [11:0] ccode_2nd;
    logic [3:0]  pat_1st;
    logic [3:0]  pat_2nd;
  } expect_t;

  state_t            state_r;
  state_t            state_s;
  logic [LATENCY-1:0] pipe_vld_r;
  logic [MXADRB-1:0] pipe_adr_r [LATENCY];
  expect_t           pipe_exp_r [LATENCY];
  expect_t           cap_exp_s;
  expect_t           last_exp_s;
  logic              cmp_vld_s;
  logic              mismatch_s;
  logic [MXADRB:0]   vec_cnt_r;
  logic [MXERRB-1:0] err_cnt_r;
  logic              first_err_valid_r;
  logic [MXADRB-1:0] first_err_adr_r;

  // State register; reset returns to IDLE regardless of the reader.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: start is only honoured while the reader has vectors left.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !rdr_done) state_s = ST_RUN;
        else                    state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (rdr_done) state_s = ST_DRAIN;
        else          state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (pipe_vld_r == '0) state_s = ST_DONE;
        else                  state_s = ST_DRAIN;
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode; increment must react to rdr_done in the same cycle.
  always_comb begin
    increment       = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    pass            = 1'b0;
    increment       = (state_r == ST_RUN) && !rdr_done;
    busy            = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    done            = (state_r == ST_DONE);
    pass            = (state_r == ST_DONE) && (err_cnt_r == '0);
    vec_cnt         = vec_cnt_r;
    err_cnt         = err_cnt_r;
    first_err_valid = first_err_valid_r;
    first_err_adr   = first_err_adr_r;
  end

  // Bundle the expected fields presented by the reader this cycle.
  always_comb begin
    cap_exp_s           = '0;
    cap_exp_s.key_1st   = key_hs_expect_1st;
    cap_exp_s.key_2nd   = key_hs_expect_2nd;
    cap_exp_s.ccode_1st = ccode_expect_1st;
    cap_exp_s.ccode_2nd = ccode_expect_2nd;
    cap_exp_s.pat_1st   = pat_expect_1st;
    cap_exp_s.pat_2nd   = pat_expect_2nd;
  end

  // Delay line matching the finder latency; a bubble enters whenever no vector is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_adr_r[i] <= '0;
        pipe_exp_r[i] <= '0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_adr_r[i] <= pipe_adr_r[i-1];
        pipe_exp_r[i] <= pipe_exp_r[i-1];
      end
      pipe_vld_r[0] <= increment;
      pipe_adr_r[0] <= rdr_adr;
      pipe_exp_r[0] <= cap_exp_s;
    end
  end

  // Compare the oldest delayed vector with the finder's current outputs.
  always_comb begin
    last_exp_s = pipe_exp_r[LATENCY-1];
    cmp_vld_s  = pipe_vld_r[LATENCY-1];
    mismatch_s = (last_exp_s.key_1st != hs_key_1st) ||
                 (last_exp_s.key_2nd != hs_key_2nd) ||
                 (last_exp_s.pat_1st != hs_pat_1st) ||
                 (last_exp_s.pat_2nd != hs_pat_2nd);
    if (CMP_CCODE != 0) begin
      mismatch_s = mismatch_s ||
                   (last_exp_s.ccode_1st != hs_ccode_1st) ||
                   (last_exp_s.ccode_2nd != hs_ccode_2nd);
    end else begin
      mismatch_s = mismatch_s;
    end
  end

  // Result counters; the error count holds at all ones and the first failure is sticky.
  always_ff @(posedge clock) begin
    if (reset) begin
      vec_cnt_r         <= '0;
      err_cnt_r         <= '0;
      first_err_valid_r <= 1'b0;
      first_err_adr_r   <= '0;
    end else if (cmp_vld_s) begin
      vec_cnt_r <= vec_cnt_r + (MXADRB+1)'(1);
      if (mismatch_s) begin
        if (err_cnt_r != {MXERRB{1'b1}}) begin
          err_cnt_r <= err_cnt_r + MXERRB'(1);
        end
        if (!first_err_valid_r) begin
          first_err_valid_r <= 1'b1;
          first_err_adr_r   <= pipe_adr_r[LATENCY-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_checker.sv
// Bench for pattern_checker: a reader model, a finder model (fixed delay of
// the expected fields with injectable faults) and a reference that derives
// every output from the list of issued vectors and their fault flags.
module tb_pattern_checker;

  localparam int AW  = 4;
  localparam int NV  = 16;
  localparam int LAT = 4;
  localparam int HN  = 200;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, start, rdr_done;
  logic [AW-1:0] rdr_adr;
  logic [7:0]  key_hs_expect_1st, key_hs_expect_2nd, hs_key_1st, hs_key_2nd;
  logic [11:0] ccode_expect_1st, ccode_expect_2nd, hs_ccode_1st, hs_ccode_2nd;
  logic [3:0]  pat_expect_1st, pat_expect_2nd, hs_pat_1st, hs_pat_2nd;

  logic o0_increment, o0_busy, o0_done, o0_pass, o0_first_err_valid;
  logic [AW:0] o0_vec_cnt;
  logic [1:0]  o0_err_cnt;
  logic [AW-1:0] o0_first_err_adr;
  logic o1_increment, o1_busy, o1_done, o1_pass, o1_first_err_valid;
  logic [AW:0] o1_vec_cnt;
  logic [3:0]  o1_err_cnt;
  logic [AW-1:0] o1_first_err_adr;

  pattern_checker #(.MXADRB(AW), .LATENCY(LAT), .MXERRB(2), .CMP_CCODE(1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start), .rdr_done(rdr_done), .rdr_adr(rdr_adr),
    .key_hs_expect_1st(key_hs_expect_1st), .key_hs_expect_2nd(key_hs_expect_2nd),
    .ccode_expect_1st(ccode_expect_1st), .ccode_expect_2nd(ccode_expect_2nd),
    .pat_expect_1st(pat_expect_1st), .pat_expect_2nd(pat_expect_2nd),
    .hs_key_1st(hs_key_1st), .hs_key_2nd(hs_key_2nd),
    .hs_ccode_1st(hs_ccode_1st), .hs_ccode_2nd(hs_ccode_2nd),
    .hs_pat_1st(hs_pat_1st), .hs_pat_2nd(hs_pat_2nd),
    .increment(o0_increment), .busy(o0_busy), .done(o0_done), .pass(o0_pass),
    .vec_cnt(o0_vec_cnt), .err_cnt(o0_err_cnt),
    .first_err_valid(o0_first_err_valid), .first_err_adr(o0_first_err_adr));

  pattern_checker #(.MXADRB(AW), .LATENCY(LAT), .MXERRB(4), .CMP_CCODE(0)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .rdr_done(rdr_done), .rdr_adr(rdr_adr),
    .key_hs_expect_1st(key_hs_expect_1st), .key_hs_expect_2nd(key_hs_expect_2nd),
    .ccode_expect_1st(ccode_expect_1st), .ccode_expect_2nd(ccode_expect_2nd),
    .pat_expect_1st(pat_expect_1st), .pat_expect_2nd(pat_expect_2nd),
    .hs_key_1st(hs_key_1st), .hs_key_2nd(hs_key_2nd),
    .hs_ccode_1st(hs_ccode_1st), .hs_ccode_2nd(hs_ccode_2nd),
    .hs_pat_1st(hs_pat_1st), .hs_pat_2nd(hs_pat_2nd),
    .increment(o1_increment), .busy(o1_busy), .done(o1_done), .pass(o1_pass),
    .vec_cnt(o1_vec_cnt), .err_cnt(o1_err_cnt),
    .first_err_valid(o1_first_err_valid), .first_err_adr(o1_first_err_adr));

  // Vector ROM contents and per-vector fault flags.
  logic [7:0]  ek1 [NV], ek2 [NV];
  logic [11:0] ec1 [NV], ec2 [NV];
  logic [3:0]  ep1 [NV], ep2 [NV];
  bit fk [NV], fp [NV], fc [NV], fside [NV];

  // Issue history: cycle index -> issued flag and address.
  bit h_vld [HN];
  int h_adr [HN];

  int cyc, rd_adr, t_done, n_inc, n_iss;
  bit rd_done;
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit mism(input int a, input bit cmp);
    return fk[a] || fp[a] || (cmp && fc[a]);
  endfunction

  // Reference: a vector issued in cycle t shows in the counters from cycle t+LAT+1.
  task automatic model(input int c, input bit cmp, input int maxe,
                       output int vc, output int ec, output int fv, output int fa);
    vc = 0; ec = 0; fv = 0; fa = 0;
    for (int t = 0; t <= c - LAT - 1; t++) begin
      if (h_vld[t]) begin
        vc++;
        if (mism(h_adr[t], cmp)) begin
          if (ec < maxe) ec++;
          if (fv == 0) begin
            fv = 1;
            fa = h_adr[t];
          end
        end
      end
    end
  endtask

  task automatic drive_inputs();
    int a;
    rdr_adr  = 4'(rd_adr);
    rdr_done = rd_done;
    key_hs_expect_1st = ek1[rd_adr]; key_hs_expect_2nd = ek2[rd_adr];
    ccode_expect_1st  = ec1[rd_adr]; ccode_expect_2nd  = ec2[rd_adr];
    pat_expect_1st    = ep1[rd_adr]; pat_expect_2nd    = ep2[rd_adr];
    if (cyc >= LAT && h_vld[cyc-LAT]) begin
      a = h_adr[cyc-LAT];
      hs_key_1st   = ek1[a] ^ ((fk[a] && !fside[a]) ? 8'h5A   : 8'h00);
      hs_key_2nd   = ek2[a] ^ ((fk[a] &&  fside[a]) ? 8'h81   : 8'h00);
      hs_pat_1st   = ep1[a] ^ ((fp[a] && !fside[a]) ? 4'h3    : 4'h0);
      hs_pat_2nd   = ep2[a] ^ ((fp[a] &&  fside[a]) ? 4'h8    : 4'h0);
      hs_ccode_1st = ec1[a] ^ ((fc[a] && !fside[a]) ? 12'h801 : 12'h000);
      hs_ccode_2nd = ec2[a] ^ ((fc[a] &&  fside[a]) ? 12'h040 : 12'h000);
    end else begin
      hs_key_1st = 8'($urandom);   hs_key_2nd = 8'($urandom);
      hs_pat_1st = 4'($urandom);   hs_pat_2nd = 4'($urandom);
      hs_ccode_1st = 12'($urandom); hs_ccode_2nd = 12'($urandom);
    end
  endtask

  task automatic check_outs(input string who, input bit cmp, input int maxe,
                            input logic inc, input logic bsy, input logic dn, input logic ps,
                            input logic [31:0] vc, input logic [31:0] ec,
                            input logic fv, input logic [31:0] fa);
    int evc, eec, efv, efa;
    bit dexp;
    model(cyc, cmp, maxe, evc, eec, efv, efa);
    dexp = (t_done >= 0) && (cyc >= t_done + LAT + 1);
    check_val({who, "_increment"}, 32'(inc), 32'((cyc >= 1) && !rd_done));
    check_val({who, "_busy"},      32'(bsy), 32'((cyc >= 1) && !dexp));
    check_val({who, "_done"},      32'(dn),  32'(dexp));
    check_val({who, "_pass"},      32'(ps),  32'(dexp && (eec == 0)));
    check_val({who, "_vec_cnt"},   vc, 32'(evc));
    check_val({who, "_err_cnt"},   ec, 32'(eec));
    check_val({who, "_ferr_vld"},  32'(fv), 32'(efv));
    check_val({who, "_ferr_adr"},  fa, 32'(efa));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_dut0"}, 32'({o0_increment, o0_busy, o0_done, o0_pass, o0_first_err_valid,
                                   o0_vec_cnt, o0_err_cnt, o0_first_err_adr}), 32'd0);
    check_val({tag, "_dut1"}, 32'({o1_increment, o1_busy, o1_done, o1_pass, o1_first_err_valid,
                                   o1_vec_cnt, o1_err_cnt, o1_first_err_adr}), 32'd0);
  endtask

  // One clock of a run: record the issue, check both DUTs, then advance the reader.
  task automatic step_run();
    bit inc_exp;
    inc_exp = (cyc >= 1) && !rd_done;
    @(negedge clock);
    h_vld[cyc] = inc_exp;
    h_adr[cyc] = rd_adr;
    if (inc_exp) n_iss++;
    if (o0_increment) n_inc++;
    if (rd_done && t_done < 0) t_done = cyc;
    check_outs("d0", 1'b1, 3,  o0_increment, o0_busy, o0_done, o0_pass,
               32'(o0_vec_cnt), 32'(o0_err_cnt), o0_first_err_valid, 32'(o0_first_err_adr));
    check_outs("d1", 1'b0, 15, o1_increment, o1_busy, o1_done, o1_pass,
               32'(o1_vec_cnt), 32'(o1_err_cnt), o1_first_err_valid, 32'(o1_first_err_adr));
    @(posedge clock);
    #1;
    start = 1'b0;
    if (inc_exp) begin
      if (rd_adr == NV - 1) rd_done = 1'b1;
      else                  rd_adr++;
    end
    cyc++;
    drive_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b1;
    rd_done = 1'b0;
    rd_adr = 0;
    cyc = 0;
    drive_inputs();
    repeat (3) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      check_idle("reset");
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check_idle("reset_release");
  endtask

  task automatic rand_vecs();
    for (int a = 0; a < NV; a++) begin
      ek1[a] = 8'($urandom);  ek2[a] = 8'($urandom);
      ec1[a] = 12'($urandom); ec2[a] = 12'($urandom);
      ep1[a] = 4'($urandom);  ep2[a] = 4'($urandom);
      fk[a] = 1'b0; fp[a] = 1'b0; fc[a] = 1'b0;
      fside[a] = 1'($urandom);
    end
  endtask

  // Full run from start; abort_n > 0 stops right after that many vectors were issued.
  task automatic run_test(input int abort_n);
    int budget;
    int evc, eec, efv, efa;
    for (int i = 0; i < HN; i++) begin
      h_vld[i] = 1'b0;
      h_adr[i] = 0;
    end
    cyc = 0; rd_adr = 0; rd_done = 1'b0; t_done = -1; n_inc = 0; n_iss = 0;
    @(posedge clock);
    #1;
    drive_inputs();
    start = 1'b1;
    budget = 0;
    while (budget < 80) begin
      step_run();
      budget++;
      if (abort_n > 0 && n_iss == abort_n) break;
      if (t_done >= 0 && cyc > t_done + LAT + 3) break;
    end
    if (abort_n == 0) begin
      check_val("run_finished", 32'((t_done >= 0) && (cyc > t_done + LAT + 3)), 32'd1);
      check_val("inc_cycles", 32'(n_inc), 32'(NV));
      check_val("vec_final", 32'(o1_vec_cnt), 32'(NV));
      model(cyc, 1'b0, 15, evc, eec, efv, efa);
      check_val("err_final_d1", 32'(o1_err_cnt), 32'(eec));
      check_val("done_final", 32'({o0_done, o1_done}), 32'd3);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rand_vecs();
    do_reset();

    // Clean run.
    rand_vecs();
    run_test(0);

    // Single pattern fault on vector 5, 1st result.
    do_reset();
    rand_vecs();
    fp[5] = 1'b1; fside[5] = 1'b0;
    run_test(0);

    // Key faults at 3 and 9, ccode-only fault at 12.
    do_reset();
    rand_vecs();
    fk[3] = 1'b1; fside[3] = 1'b0;
    fk[9] = 1'b1; fside[9] = 1'b1;
    fc[12] = 1'b1;
    run_test(0);

    // Mid-run reset after vector 7 has been issued.
    do_reset();
    rand_vecs();
    run_test(8);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_idle("midrun_reset");
    @(posedge clock);
    #1;
    rd_done = 1'b1;
    drive_inputs();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_idle("start_while_rdr_done");
    end

    // Every vector mismatches: saturation and first failure at address 0.
    do_reset();
    rand_vecs();
    for (int a = 0; a < NV; a++) fp[a] = 1'b1;
    run_test(0);

    // Random fault mix.
    do_reset();
    rand_vecs();
    for (int a = 0; a < NV; a++) begin
      case ($urandom_range(0, 5))
        0: fk[a] = 1'b1;
        1: fp[a] = 1'b1;
        2: fc[a] = 1'b1;
        default: ;
      endcase
    end
    run_test(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
